// File: rtl/gpio_pad_ctrl.sv
// Direction/turnaround controller and input synchroniser + glitch filter for one bidirectional GPIO pad.
// Optional edge counter enabled by defining GPIO_PAD_CTRL_EDGE_COUNT_EN.
module gpio_pad_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic                i_clk,
  input  logic                i_arstn,
  input  logic                i_dirReq,
  input  logic                i_outValue,
  input  logic [FILTER_W-1:0] i_filterLen,
  output logic                o_padOutputEnable,
  output logic                o_padXOut,
  input  logic                i_padXIn,
  output logic                o_in,
  output logic                o_rise,
  output logic                o_fall,
  output logic                o_dirAck
`ifdef GPIO_PAD_CTRL_EDGE_COUNT_EN
  ,
  input  logic                i_edgeCountClr,
  output logic [7:0]          o_edgeCount
`endif
);

  localparam int TURN_LEN  = (TURN_CYCLES < 1) ? 1 : TURN_CYCLES;
  localparam int FLUSH_LEN = TURN_LEN + SYNC_STAGES;
  localparam int TCNT_W    = $clog2(FLUSH_LEN + 1);
  localparam logic [TCNT_W-1:0] TURN_LAST  = TCNT_W'(TURN_LEN - 1);
  localparam logic [TCNT_W-1:0] FLUSH_LAST = TCNT_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [TCNT_W-1:0]      turn_cnt_q, turn_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILTER_W-1:0]    filt_cnt_q, filt_cnt_d;
  logic                   oe_q, oe_d;
  logic                   xout_q, xout_d;
  logic                   in_q, in_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   ack_q, ack_d;
  logic                   synced;
  logic                   fire;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q + TCNT_W'(1);
    case (state_q)
      ST_IN: begin
        turn_cnt_d = '0;
        if (i_dirReq) state_d = ST_TURN_OUT;
      end
      ST_TURN_OUT: begin
        if (!i_dirReq) begin
          state_d    = ST_IN;
          turn_cnt_d = '0;
        end else if (turn_cnt_q == TURN_LAST) begin
          state_d    = ST_OUT;
          turn_cnt_d = '0;
        end
      end
      ST_OUT: begin
        turn_cnt_d = '0;
        if (!i_dirReq) state_d = ST_TURN_IN;
      end
      ST_TURN_IN: begin
        // Stay released long enough for the driven 0s to drain out of the synchroniser.
        if (i_dirReq) begin
          state_d    = ST_TURN_OUT;
          turn_cnt_d = '0;
        end else if (turn_cnt_q == FLUSH_LAST) begin
          state_d    = ST_IN;
          turn_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IN;
        turn_cnt_d = '0;
      end
    endcase

    oe_d   = (state_d == ST_OUT);
    xout_d = oe_d & i_outValue;
    ack_d  = ((state_d == ST_OUT) & i_dirReq) | ((state_d == ST_IN) & ~i_dirReq);
  end

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], i_padXIn};
    in_d       = in_q;
    filt_cnt_d = '0;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    fire       = 1'b0;
    // The counter saturates at the compare, so it can never wrap past the max length.
    if ((state_q == ST_IN) && (synced != in_q)) begin
      if (filt_cnt_q >= i_filterLen) begin
        fire   = 1'b1;
        in_d   = synced;
        rise_d = synced;
        fall_d = ~synced;
      end else begin
        filt_cnt_d = filt_cnt_q + FILTER_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q    <= ST_IN;
      turn_cnt_q <= '0;
      sync_q     <= '0;
      filt_cnt_q <= '0;
      oe_q       <= 1'b0;
      xout_q     <= 1'b0;
      in_q       <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      sync_q     <= sync_d;
      filt_cnt_q <= filt_cnt_d;
      oe_q       <= oe_d;
      xout_q     <= xout_d;
      in_q       <= in_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ack_q      <= ack_d;
    end
  end

  assign o_padOutputEnable = oe_q;
  assign o_padXOut         = xout_q;
  assign o_in              = in_q;
  assign o_rise            = rise_q;
  assign o_fall            = fall_q;
  assign o_dirAck          = ack_q;

`ifdef GPIO_PAD_CTRL_EDGE_COUNT_EN
  logic [7:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (i_edgeCountClr) edge_cnt_d = '0;
    else if (fire)      edge_cnt_d = edge_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) edge_cnt_q <= '0;
    else          edge_cnt_q <= edge_cnt_d;
  end

  assign o_edgeCount = edge_cnt_q;
`else
  logic unused_fire;
  assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios plus random traffic against a behavioural pad model.
// Edge-counter checks compile in when GPIO_PAD_CTRL_EDGE_COUNT_EN is defined.
module tb_gpio_pad_ctrl;
  localparam int SYNC = 2;
  localparam int FW   = 4;
  localparam int TURN = 2;

  logic          clk      = 1'b0;
  logic          arstn    = 1'b0;
  logic          dir_req  = 1'b0;
  logic          out_val  = 1'b0;
  logic          pad_in   = 1'b0;
  logic [FW-1:0] filt_len = '0;
  logic          oe, xout, in_lvl, rise, fall, ack;
`ifdef GPIO_PAD_CTRL_EDGE_COUNT_EN
  logic          ec_clr = 1'b0;
  logic [7:0]    ecount;
`endif

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.SYNC_STAGES(SYNC), .FILTER_W(FW), .TURN_CYCLES(TURN)) dut (
    .i_clk             (clk),
    .i_arstn           (arstn),
    .i_dirReq          (dir_req),
    .i_outValue        (out_val),
    .i_filterLen       (filt_len),
    .o_padOutputEnable (oe),
    .o_padXOut         (xout),
    .i_padXIn          (pad_in),
    .o_in              (in_lvl),
    .o_rise            (rise),
    .o_fall            (fall),
    .o_dirAck          (ack)
`ifdef GPIO_PAD_CTRL_EDGE_COUNT_EN
    ,
    .i_edgeCountClr    (ec_clr),
    .o_edgeCount       (ecount)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pad direction as a phase with a count of cycles spent in it,
  // input level seen through a SYNC-deep history, filter as a mismatch run length.
  typedef enum int {P_IN, P_TO, P_OUT, P_TI} phase_e;
  phase_e m_ph;
  int     m_spent;
  bit     m_hist[$];
  int     m_run;
  bit     m_in, m_rise, m_fall, m_oe, m_x, m_ack;
  int     m_ecnt;

  function automatic int guard_len();
    return (TURN < 1) ? 1 : TURN;
  endfunction

  task automatic model_reset();
    m_ph = P_IN; m_spent = 0; m_run = 0;
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_in = 0; m_rise = 0; m_fall = 0; m_oe = 0; m_x = 0; m_ack = 0; m_ecnt = 0;
  endtask

  task automatic model_step();
    bit seen;
    seen   = m_hist[SYNC-1];
    m_rise = 0;
    m_fall = 0;
    if (m_ph == P_IN && seen != m_in) begin
      if (m_run >= int'(filt_len)) begin
        m_in = seen; m_rise = seen; m_fall = !seen; m_run = 0;
      end else begin
        m_run++;
      end
    end else begin
      m_run = 0;
    end
`ifdef GPIO_PAD_CTRL_EDGE_COUNT_EN
    if (ec_clr) m_ecnt = 0;
    else if (m_rise || m_fall) m_ecnt = (m_ecnt + 1) % 256;
`endif
    m_hist.push_front(pad_in);
    void'(m_hist.pop_back());
    case (m_ph)
      P_IN:  if (dir_req) begin m_ph = P_TO; m_spent = 0; end
      P_TO:  if (!dir_req) m_ph = P_IN;
             else begin m_spent++; if (m_spent >= guard_len()) m_ph = P_OUT; end
      P_OUT: if (!dir_req) begin m_ph = P_TI; m_spent = 0; end
      P_TI:  if (dir_req) begin m_ph = P_TO; m_spent = 0; end
             else begin m_spent++; if (m_spent >= guard_len() + SYNC) m_ph = P_IN; end
      default: m_ph = P_IN;
    endcase
    m_oe  = (m_ph == P_OUT);
    m_x   = m_oe && out_val;
    m_ack = (m_ph == P_OUT && dir_req) || (m_ph == P_IN && !dir_req);
  endtask

  task automatic compare_all();
    check_val("oe", oe, m_oe);
    check_val("xout", xout, m_x);
    check_val("in", in_lvl, m_in);
    check_val("rise", rise, m_rise);
    check_val("fall", fall, m_fall);
    check_val("ack", ack, m_ack);
    check_val("rise_fall_excl", rise & fall, 0);
`ifdef GPIO_PAD_CTRL_EDGE_COUNT_EN
    check_val("edge_count", ecount, m_ecnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_pad(input int hi, output int strobes);
    strobes = 0;
    pad_in = 1'b1;
    repeat (hi) begin tick(); strobes += rise + fall; end
    pad_in = 1'b0;
    repeat (10) begin tick(); strobes += rise + fall; end
  endtask

  initial begin
    int lat;
    int strobes;
    bit oe_seen;
    bit lvl;

    model_reset();
    #12;
    check_val("rst_oe", oe, 0);
    check_val("rst_xout", xout, 0);
    check_val("rst_in", in_lvl, 0);
    check_val("rst_rise", rise, 0);
    check_val("rst_fall", fall, 0);
    check_val("rst_ack", ack, 0);
    @(negedge clk);
    arstn = 1'b1;
    tick();
    check_val("ack_after_rst", ack, 1);

    // Stable step through the filter.
    filt_len = 4'd3;
    repeat (3) tick();
    pad_in = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (in_lvl !== 1'b1 && lat < 20);
    check_val("rise_latency", lat, 6);
    check_val("rise_strobe", rise, 1);
    tick();
    check_val("rise_one_cycle", rise, 0);
    pad_in = 1'b0;
    repeat (10) tick();
    check_val("fall_back", in_lvl, 0);

    // Short glitches are swallowed.
    pulse_pad(1, strobes);
    check_val("glitch1_strobes", strobes, 0);
    pulse_pad(3, strobes);
    check_val("glitch3_strobes", strobes, 0);
    check_val("glitch_in", in_lvl, 0);

    // Direction change with guard cycles.
    out_val = 1'b1;
    dir_req = 1'b1;
    tick();
    tick();
    check_val("turn_out_oe_early", oe, 0);
    tick();
    check_val("out_oe", oe, 1);
    check_val("out_xout", xout, 1);
    check_val("out_ack", ack, 1);
    dir_req = 1'b0;
    tick();
    check_val("turn_in_oe", oe, 0);
    check_val("turn_in_ack", ack, 0);
    repeat (3) tick();
    check_val("turn_in_ack_late", ack, 0);
    tick();
    check_val("in_ack_back", ack, 1);

    // One-cycle request aborts before driving.
    dir_req = 1'b1;
    tick();
    dir_req = 1'b0;
    oe_seen = 1'b0;
    repeat (6) begin tick(); oe_seen |= oe; end
    check_val("pulse_no_oe", oe_seen, 0);
    check_val("pulse_ack", ack, 1);

    // Random traffic.
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  dir_req = ~dir_req;
      if ($urandom_range(0, 5) == 0)  lvl = ~lvl;
      if ($urandom_range(0, 49) == 0)
        filt_len = ($urandom_range(0, 9) == 0) ? FW'($urandom_range(0, 15)) : FW'($urandom_range(0, 5));
      out_val = 1'($urandom_range(0, 1));
      pad_in  = oe ? 1'b0 : lvl;
      tick();
    end

    // Async reset while driving.
    pad_in  = 1'b0;
    dir_req = 1'b1;
    repeat (5) tick();
    check_val("pre_arst_oe", oe, 1);
    #2 arstn = 1'b0;
    #1;
    check_val("arst_oe_drop", oe, 0);
    model_reset();
    dir_req = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    tick();
    check_val("arst_ack", ack, 1);

`ifdef GPIO_PAD_CTRL_EDGE_COUNT_EN
    filt_len = '0;
    ec_clr = 1'b1;
    tick();
    ec_clr = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 5; i++) begin
      pad_in = ~pad_in;
      repeat (4) tick();
    end
    check_val("five_edges", ecount, 5);
    pad_in = ~pad_in;
    tick();
    tick();
    ec_clr = 1'b1;
    tick();
    ec_clr = 1'b0;
    check_val("clr_edge_strobe", rise | fall, 1);
    check_val("clr_wins", ecount, 0);
    repeat (4) tick();
    for (int i = 0; i < 256; i++) begin
      pad_in = ~pad_in;
      repeat (3) tick();
    end
    check_val("wrap_256", ecount, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
